// File: rtl/stack16_reader_pkg.sv
// cookie_pkg: shared word/depth defaults and occupancy-state encoding for stack16_reader.
package cookie_pkg;
  localparam int WORD_WIDTH = 16;
  localparam int STACK_DEPTH = 16;
  typedef enum logic [1:0] {
    OCC_EMPTY   = 2'd0,
    OCC_PARTIAL = 2'd1,
    OCC_FULL    = 2'd2
  } occ_e;
  function automatic occ_e occ_of(int c, int d);
    return c == 0 ? OCC_EMPTY : c == d ? OCC_FULL : OCC_PARTIAL;
  endfunction
endpackage

// File: rtl/stack16_reader_if.sv
// stack16_reader_if: push/pop request and status bundle of the stack.
interface stack16_reader_if import cookie_pkg::*; #(
  parameter int WIDTH = WORD_WIDTH,
  parameter int DEPTH = STACK_DEPTH
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic [WIDTH-1:0] din, dout;
  logic push, pop, pop_valid, empty, full, err;
  logic [CW-1:0] count;
  modport master (output din, push, pop, input dout, pop_valid, empty, full, count, err);
  modport slave (input din, push, pop, output dout, pop_valid, empty, full, count, err);
endinterface

// File: rtl/stack16_reader_mem.sv
// stack_mem: stack storage, synchronous write, combinational read, no reset.
module stack_mem #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/stack16_reader.sv
// stack16_reader: LIFO with registered pop output; define STACK_ERR_STICKY_EN to make err sticky until reset.
module stack16_reader import cookie_pkg::*; #(
  parameter int WIDTH = WORD_WIDTH,
  parameter int DEPTH = STACK_DEPTH
) (
  input logic             clk,
  input logic             reset,
  stack16_reader_if.slave s
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [CW-1:0] count_q, count_d, cm1;
  logic [AW-1:0] top, waddr;
  logic [WIDTH-1:0] rdata, dout_q, dout_d;
  logic pv_q, pv_d, err_q, err_d, we, hit, bad;
  occ_e occ_q, occ_d;
  stack_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
    .clk(clk), .we(we), .waddr(waddr), .wdata(s.din), .raddr(top), .rdata(rdata)
  );
  always_comb begin
    cm1 = count_q - CW'(1);
    top = cm1[AW-1:0];
    hit = s.pop && occ_q != OCC_EMPTY;
    // a simultaneous push+pop replaces the top in place instead of growing
    we = s.push && (s.pop ? occ_q != OCC_EMPTY : occ_q != OCC_FULL);
    waddr = s.pop ? top : count_q[AW-1:0];
    count_d = s.push && !s.pop && occ_q != OCC_FULL ? count_q + CW'(1) : !s.push && hit ? cm1 : count_q;
    occ_d = occ_of(int'(count_d), DEPTH);
    pv_d = s.pop && (s.push || hit);
    dout_d = hit ? rdata : pv_d ? s.din : dout_q;
    bad = s.push != s.pop && (s.push ? occ_q == OCC_FULL : occ_q == OCC_EMPTY);
`ifdef STACK_ERR_STICKY_EN
    err_d = err_q | bad;
`else
    err_d = bad;
`endif
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      count_q <= '0;
      occ_q <= OCC_EMPTY;
      dout_q <= '0;
      pv_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      count_q <= count_d;
      occ_q <= occ_d;
      dout_q <= dout_d;
      pv_q <= pv_d;
      err_q <= err_d;
    end
  assign s.count = count_q;
  assign s.empty = occ_q == OCC_EMPTY;
  assign s.full = occ_q == OCC_FULL;
  assign s.dout = dout_q;
  assign s.pop_valid = pv_q;
  assign s.err = err_q;
endmodule

// File: tb/tb_stack16_reader.sv
// tb_stack16_reader: scoreboard bench for stack16_reader against a queue-based LIFO model.
module tb_stack16_reader;
  localparam int W = 16;
  localparam int D = 16;
  typedef struct {
    int cnt;
    bit err;
    bit pv;
    int dout;
  } stat_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  stack16_reader_if #(.WIDTH(W), .DEPTH(D)) bus ();
  stack16_reader #(.WIDTH(W), .DEPTH(D)) dut (.clk(clk), .reset(reset), .s(bus.slave));
  always #5 clk = ~clk;
  int total = 0;
  int bad = 0;
  int stk[$];
  int dq[$];
  stat_t sq[$];
  bit errm = 0;
  int lastd = 0;
  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    stk.delete();
    dq.delete();
    sq.delete();
    errm = 0;
    lastd = 0;
  endtask
  task automatic step(input bit pu, input bit po, input int d);
    bit pv = 0;
    bit e = 0;
    int v = 0;
    bus.push = pu;
    bus.pop = po;
    bus.din = W'(d);
    if (pu && po) begin
      pv = 1;
      if (stk.size() == 0) v = d;
      else begin
        v = stk[$];
        stk[stk.size()-1] = d;
      end
    end else if (pu) begin
      if (stk.size() == D) e = 1;
      else stk.push_back(d);
    end else if (po) begin
      if (stk.size() == 0) e = 1;
      else begin
        v = stk.pop_back();
        pv = 1;
      end
    end
`ifdef STACK_ERR_STICKY_EN
    errm = errm | e;
`else
    errm = e;
`endif
    if (pv) begin
      dq.push_back(v);
      lastd = v;
    end
    sq.push_back('{stk.size(), errm, pv, lastd});
    @(negedge clk);
  endtask
  initial begin : monitor
    stat_t s;
    forever begin
      @(posedge clk);
      #1;
      if (sq.size() != 0) begin
        s = sq.pop_front();
        chk("count", int'(bus.count), s.cnt);
        chk("empty", int'(bus.empty), int'(s.cnt == 0));
        chk("full", int'(bus.full), int'(s.cnt == D));
        chk("err", int'(bus.err), int'(s.err));
        chk("pop_valid", int'(bus.pop_valid), int'(s.pv));
        chk("dout_hold", int'(bus.dout), s.dout);
        if (bus.pop_valid) begin
          if (dq.size() == 0) chk("pop_data_unexpected", 1, 0);
          else chk("pop_data", int'(bus.dout), dq.pop_front());
        end
      end
    end
  end
  task automatic reset_checks(input string tag);
    chk({tag, "_count"}, int'(bus.count), 0);
    chk({tag, "_empty"}, int'(bus.empty), 1);
    chk({tag, "_full"}, int'(bus.full), 0);
    chk({tag, "_dout"}, int'(bus.dout), 0);
    chk({tag, "_pv"}, int'(bus.pop_valid), 0);
    chk({tag, "_err"}, int'(bus.err), 0);
  endtask
  initial begin : stim
    int t;
    bus.push = 1'b1;
    bus.pop = 1'b0;
    bus.din = W'(10);
    repeat (3) @(negedge clk);
    reset_checks("rst_hold");
    reset = 1'b1;
    step(1, 0, 10);
    step(1, 0, 20);
    step(1, 0, 30);
    step(0, 1, 0);
    step(0, 1, 0);
    step(0, 1, 0);
    step(0, 1, 0);
    step(1, 1, 7);
    step(0, 0, 0);
    for (int i = 1; i <= 16; i++) step(1, 0, i);
    step(1, 0, 99);
    step(0, 1, 0);
    for (int i = 0; i < 15; i++) step(0, 1, 0);
    step(1, 0, 5);
    step(1, 0, 6);
    step(1, 1, 8);
    step(0, 1, 0);
    step(0, 1, 0);
    step(0, 1, 0);
    step(1, 0, 1);
    step(0, 0, 0);
    step(0, 0, 0);
    for (int i = 0; i < 600; i++) begin
      bit ph;
      ph = ((i / 40) % 2) == 1;
      if (i == 300) begin
        model_reset();
        #1 reset = 1'b0;
        #1 reset_checks("rst_async");
        @(negedge clk);
        reset = 1'b1;
      end
      step($urandom_range(99) < (ph ? 25 : 80), $urandom_range(99) < (ph ? 75 : 30), int'($urandom_range(16'hffff)));
    end
    bus.push = 1'b0;
    bus.pop = 1'b0;
    t = 0;
    while (sq.size() != 0 && t < 10) begin
      @(negedge clk);
      t++;
    end
    if (sq.size() != 0) chk("drain_timeout", sq.size(), 0);
    chk("pop_queue_left", dq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/stack16_reader.md
STACK16_READER -- requirements
Module: stack16_reader

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data word width.
REQ-002 SHALL have parameter DEPTH, default 16, entry count (power of two, min 2).
REQ-003 SHALL have port clk  input  1  rising-edge clock; the design uses one clock.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port din  input  WIDTH  push data.
REQ-006 SHALL have port push  input  1  push request, sampled on the rising clk edge.
REQ-007 SHALL have port pop  input  1  pop/read request, sampled on the rising clk edge.
REQ-008 SHALL have port dout  output  WIDTH  registered popped word.
REQ-009 SHALL have port pop_valid  output  1  one-cycle pulse; dout holds a newly popped word.
REQ-010 SHALL have port empty  output  1  count == 0.
REQ-011 SHALL have port full  output  1  count == DEPTH.
REQ-012 SHALL have port count  output  log2(DEPTH)+1  current occupancy.
REQ-013 SHALL have port err  output  1  overflow/underflow indication.

Function
REQ-014 SHALL keep the stack pointer sp equal to count; a push writes mem[sp], and the top of stack is mem[sp-1].
REQ-015 On push only, when not full: SHALL write din to mem[sp] and set count to count+1.
REQ-016 On pop only, when not empty: SHALL register mem[sp-1] into dout on the same edge, pulse pop_valid for exactly that next cycle, and set count to count-1.
REQ-017 Pop latency SHALL be 1 cycle, from the sampling edge to valid dout.
REQ-018 On push and pop together, when not empty: SHALL output the old top on dout with pop_valid=1, overwrite mem[sp-1] with din, and leave count unchanged.
REQ-019 On push and pop together, when empty: SHALL pass din through to dout with pop_valid=1, write nothing to mem, and keep count at 0.
REQ-020 On push alone when full: SHALL write nothing, leave count unchanged, and raise err.
REQ-021 On pop alone when empty: SHALL leave dout and count unchanged, keep pop_valid at 0, and raise err.
REQ-022 dout SHALL hold its last value while pop_valid is 0.
REQ-023 empty, full and count SHALL be registered and reflect the post-edge occupancy.
REQ-024 Occupancy states are EMPTY (count=0), PARTIAL, and FULL (count=DEPTH); transitions occur only through REQ-015 to REQ-021, and there is no wrap-around.

Reset
REQ-025 While reset is low: count=0, empty=1, full=0, dout=0, pop_valid=0, err=0, held asynchronously.
REQ-026 Reset mid-operation SHALL discard the stack contents logically; mem need not be cleared.
REQ-027 Requests on the first edge after reset deasserts SHALL be honoured normally.

Configuration
REQ-028 With STACK_ERR_STICKY_EN defined: err SHALL stay high once set, until reset.
REQ-029 Without STACK_ERR_STICKY_EN: err SHALL pulse for one cycle per offending request.

Structure
REQ-030 Shared package cookie_pkg SHALL hold WORD_WIDTH=16, STACK_DEPTH=16, and the occupancy-state encoding constants.
REQ-031 Storage SHALL be the sub-module stack_mem: synchronous write, combinational read of the top address, no reset.
REQ-032 The top level SHALL contain the pointer, count, flag and output register logic.

Verification
REQ-033 Hold reset low, push=1 -> count=0, empty=1, dout=0; after release, push 10 -> count=1, empty=0.
REQ-034 Push 10, 20, 30, then pop x3 -> dout 30, 20, 10 on consecutive cycles, pop_valid high each cycle, ending empty=1.
REQ-035 Fill 16 words (1..16), then push 99 -> full=1, count=16, err=1; pop -> dout=16.
REQ-036 On empty, pop -> pop_valid=0, err=1, dout unchanged; on empty, push+pop with din=7 -> dout=7, pop_valid=1, count=0.
REQ-037 Stack holds 5, 6; push+pop with din=8 -> dout=6, count=2; then pop -> dout=8.
REQ-038 Underflow followed by a valid push: err stays 1 with STACK_ERR_STICKY_EN, and returns to 0 after one cycle without it.
